// File: rtl/sr_dmem_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: master identifiers used by the
// grant picker and the read-return routing.
package sr_dmem_arbiter_pkg;

    // Master IDs; M1 is the reset owner so M0 wins the first tie.
    typedef enum logic {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } master_e;

endpackage

// File: rtl/sr_dmem_arbiter_if.sv
// Bus bundle for the data-RAM arbiter.
//   m0_* / m1_* : requester ports (req, we, addr, wd in; gnt, rvalid, rd out)
//   mem_*       : single-port synchronous RAM port (en, we, addr, wd out; rd in)
// slave  : arbiter view.
// master : requesters plus RAM view (the side that drives req/wd and mem_rd).
interface sr_dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wd;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rd;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wd;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rd;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] mem_rd;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wd,
        output m0_gnt, m0_rvalid, m0_rd,
        input  m1_req, m1_we, m1_addr, m1_wd,
        output m1_gnt, m1_rvalid, m1_rd,
        output mem_en, mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wd,
        input  m0_gnt, m0_rvalid, m0_rd,
        output m1_req, m1_we, m1_addr, m1_wd,
        input  m1_gnt, m1_rvalid, m1_rd,
        input  mem_en, mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/sr_dmem_arbiter_pick.sv
// Combinational winner select for the data-RAM arbiter.
//   req0/req1  : qualified requests
//   last_owner : master granted most recently
//   burst_lim  : owner has used up its burst allowance (or no owner yet)
//   gnt0/gnt1  : one-hot grant (both 0 when idle)
//   winner     : granted master, meaningful only when a grant is issued
module sr_arb_pick
    import sr_dmem_arbiter_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  master_e last_owner,
    input  logic    burst_lim,
    output logic    gnt0,
    output logic    gnt1,
    output master_e winner
);

    // Lone requester always wins; on a tie the owner keeps going until its burst is spent.
    always_comb begin
        winner = last_owner;
        if (req0 && req1) begin
            if (burst_lim) begin
                winner = (last_owner == ARB_M0) ? ARB_M1 : ARB_M0;
            end
        end else if (req0) begin
            winner = ARB_M0;
        end else if (req1) begin
            winner = ARB_M1;
        end
        gnt0 = (req0 || req1) && (winner == ARB_M0);
        gnt1 = (req0 || req1) && (winner == ARB_M1);
    end

endmodule

// File: rtl/sr_dmem_arbiter.sv
// Two-master arbiter in front of one single-port synchronous data RAM.
// Grant and RAM drive are combinational in the request cycle; read data
// returns one cycle later to the master that issued the read.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester ports m0_*/m1_* and RAM port mem_*
module sr_dmem_arbiter
    import sr_dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sr_dmem_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W   = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam int unsigned CNT_TOP = BURST_MAX - 1;

    master_e            last_owner_q, last_owner_d;
    logic               owner_vld_q,  owner_vld_d;
    logic [CNT_W-1:0]   burst_cnt_q,  burst_cnt_d;
    logic               rd_pend_q,    rd_pend_d;
    master_e            rd_tag_q,     rd_tag_d;

    logic               req0, req1, gnt0, gnt1, any_gnt, burst_lim, cnt_sat;
    master_e            winner;

    // Requests are masked in reset so no grant or RAM strobe leaks out.
    assign req0    = bus.m0_req && rst_n;
    assign req1    = bus.m1_req && rst_n;
    assign cnt_sat = (burst_cnt_q >= CNT_W'(CNT_TOP));
    // Until the first grant there is no real owner, so a tie goes to the non-reset owner (M0).
    assign burst_lim = !owner_vld_q || cnt_sat;

    sr_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_owner (last_owner_q),
        .burst_lim  (burst_lim),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .winner     (winner)
    );

    assign any_gnt = gnt0 || gnt1;

    // RAM drive from the granted master; zero when idle.
    always_comb begin
        bus.m0_gnt   = gnt0;
        bus.m1_gnt   = gnt1;
        bus.mem_en   = any_gnt;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_wd   = '0;
        if (gnt0) begin
            bus.mem_we   = bus.m0_we;
            bus.mem_addr = bus.m0_addr;
            bus.mem_wd   = bus.m0_wd;
        end else if (gnt1) begin
            bus.mem_we   = bus.m1_we;
            bus.mem_addr = bus.m1_addr;
            bus.mem_wd   = bus.m1_wd;
        end
    end

    // Owner/burst bookkeeping and read-return tagging.
    always_comb begin
        last_owner_d = last_owner_q;
        owner_vld_d  = owner_vld_q;
        burst_cnt_d  = burst_cnt_q;
        rd_pend_d    = 1'b0;
        rd_tag_d     = rd_tag_q;
        if (any_gnt) begin
            owner_vld_d = 1'b1;
            if (winner == last_owner_q) begin
                if (!cnt_sat) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end else begin
                last_owner_d = winner;
                burst_cnt_d  = '0;
            end
            if (!bus.mem_we) begin
                rd_pend_d = 1'b1;
                rd_tag_d  = winner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner_q <= ARB_M1;
            owner_vld_q  <= 1'b0;
            burst_cnt_q  <= '0;
            rd_pend_q    <= 1'b0;
            rd_tag_q     <= ARB_M0;
        end else begin
            last_owner_q <= last_owner_d;
            owner_vld_q  <= owner_vld_d;
            burst_cnt_q  <= burst_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_tag_q     <= rd_tag_d;
        end
    end

    // Return path: RAM data goes only to the tagged master, zero elsewhere.
    always_comb begin
        bus.m0_rvalid = rd_pend_q && (rd_tag_q == ARB_M0);
        bus.m1_rvalid = rd_pend_q && (rd_tag_q == ARB_M1);
        bus.m0_rd     = bus.m0_rvalid ? bus.mem_rd : '0;
        bus.m1_rd     = bus.m1_rvalid ? bus.mem_rd : '0;
    end

endmodule

// File: tb/tb_sr_dmem_arbiter.sv
// Directed bench for sr_dmem_arbiter: instance a (BURST_MAX=4) carries most
// scenarios, instance b (BURST_MAX=1) checks strict alternation.
module tb_sr_dmem_arbiter;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    sr_dmem_arbiter_if #(.AW(32), .DW(32)) if_a ();
    sr_dmem_arbiter_if #(.AW(32), .DW(32)) if_b ();

    sr_dmem_arbiter #(.AW(32), .DW(32), .BURST_MAX(4)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    sr_dmem_arbiter #(.AW(32), .DW(32), .BURST_MAX(1)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM models, preloaded on reset.
    logic [31:0] ram_a [64];
    logic [31:0] ram_b [64];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ram_a[i] <= 32'h0;
            ram_a[0]     <= 32'hA0A0_A0A0;
            ram_a[1]     <= 32'hB1B1_B1B1;
            ram_a[4]     <= 32'hDEAD_BEEF;
            if_a.mem_rd  <= 32'h0;
        end else if (if_a.mem_en) begin
            if (if_a.mem_we) ram_a[if_a.mem_addr[7:2]] <= if_a.mem_wd;
            else             if_a.mem_rd <= ram_a[if_a.mem_addr[7:2]];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) ram_b[i] <= 32'h0;
            if_b.mem_rd <= 32'h0;
        end else if (if_b.mem_en) begin
            if (if_b.mem_we) ram_b[if_b.mem_addr[7:2]] <= if_b.mem_wd;
            else             if_b.mem_rd <= ram_b[if_b.mem_addr[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        if_a.m0_req = 1'b1; if_a.m0_we = 1'b0; if_a.m0_addr = 32'h40; if_a.m0_wd = 32'h0;
        if_a.m1_req = 1'b1; if_a.m1_we = 1'b0; if_a.m1_addr = 32'h44; if_a.m1_wd = 32'h0;
        if_b.m0_req = 1'b0; if_b.m0_we = 1'b0; if_b.m0_addr = 32'h0;  if_b.m0_wd = 32'h0;
        if_b.m1_req = 1'b0; if_b.m1_we = 1'b0; if_b.m1_addr = 32'h0;  if_b.m1_wd = 32'h0;

        // 1. In reset with both requesting: nothing granted or returned.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m0_gnt",    32'(if_a.m0_gnt),    32'h0);
        chk("rst_m1_gnt",    32'(if_a.m1_gnt),    32'h0);
        chk("rst_mem_en",    32'(if_a.mem_en),    32'h0);
        chk("rst_mem_addr",  if_a.mem_addr,       32'h0);
        chk("rst_m0_rvalid", 32'(if_a.m0_rvalid), 32'h0);
        chk("rst_m1_rvalid", 32'(if_a.m1_rvalid), 32'h0);
        chk("rst_m0_rd",     if_a.m0_rd,          32'h0);

        // 1+3. Release with both requesting: M0 x4, M1 x4, M0.
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("burst4_m0_gnt[%0d]", i), 32'(if_a.m0_gnt), ((i / 4) % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("burst4_m1_gnt[%0d]", i), 32'(if_a.m1_gnt), ((i / 4) % 2 == 1) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        if_a.m0_req = 1'b0;
        if_a.m1_req = 1'b0;
        #1;
        chk("idle_mem_en", 32'(if_a.mem_en), 32'h0);

        // 2. M0 read of 0x10.
        @(negedge clk);
        if_a.m0_req = 1'b1; if_a.m0_we = 1'b0; if_a.m0_addr = 32'h10;
        #1;
        chk("rd10_m0_gnt",   32'(if_a.m0_gnt), 32'h1);
        chk("rd10_m1_gnt",   32'(if_a.m1_gnt), 32'h0);
        chk("rd10_mem_en",   32'(if_a.mem_en), 32'h1);
        chk("rd10_mem_we",   32'(if_a.mem_we), 32'h0);
        chk("rd10_mem_addr", if_a.mem_addr,    32'h10);
        @(negedge clk);
        if_a.m0_req = 1'b0;
        #1;
        chk("rd10_m0_rvalid", 32'(if_a.m0_rvalid), 32'h1);
        chk("rd10_m0_rd",     if_a.m0_rd,          32'hDEAD_BEEF);
        chk("rd10_m1_rvalid", 32'(if_a.m1_rvalid), 32'h0);
        chk("rd10_m1_rd",     if_a.m1_rd,          32'h0);

        // 4. M1 write 0x20, then M0 reads it back.
        @(negedge clk);
        if_a.m1_req = 1'b1; if_a.m1_we = 1'b1; if_a.m1_addr = 32'h20; if_a.m1_wd = 32'h1234_5678;
        #1;
        chk("wr20_m1_gnt", 32'(if_a.m1_gnt), 32'h1);
        chk("wr20_mem_we", 32'(if_a.mem_we), 32'h1);
        chk("wr20_mem_wd", if_a.mem_wd,      32'h1234_5678);
        @(negedge clk);
        if_a.m1_req = 1'b0; if_a.m1_we = 1'b0;
        if_a.m0_req = 1'b1; if_a.m0_we = 1'b0; if_a.m0_addr = 32'h20;
        #1;
        chk("rd20_m0_gnt",    32'(if_a.m0_gnt),    32'h1);
        chk("wr20_m1_rvalid", 32'(if_a.m1_rvalid), 32'h0);
        chk("wr20_m0_rvalid", 32'(if_a.m0_rvalid), 32'h0);
        @(negedge clk);
        if_a.m0_req = 1'b0;
        #1;
        chk("rd20_m0_rvalid", 32'(if_a.m0_rvalid), 32'h1);
        chk("rd20_m0_rd",     if_a.m0_rd,          32'h1234_5678);

        // 5. Back-to-back M0@0x0 then M1@0x4.
        @(negedge clk);
        if_a.m0_req = 1'b1; if_a.m0_addr = 32'h0;
        #1;
        chk("il_m0_gnt", 32'(if_a.m0_gnt), 32'h1);
        @(negedge clk);
        if_a.m0_req = 1'b0;
        if_a.m1_req = 1'b1; if_a.m1_we = 1'b0; if_a.m1_addr = 32'h4;
        #1;
        chk("il_m1_gnt",     32'(if_a.m1_gnt),    32'h1);
        chk("il_m0_rvalid",  32'(if_a.m0_rvalid), 32'h1);
        chk("il_m0_rd",      if_a.m0_rd,          32'hA0A0_A0A0);
        chk("il_m1_rvalid0", 32'(if_a.m1_rvalid), 32'h0);
        chk("il_m1_rd0",     if_a.m1_rd,          32'h0);
        @(negedge clk);
        if_a.m1_req = 1'b0;
        #1;
        chk("il_m1_rvalid",  32'(if_a.m1_rvalid), 32'h1);
        chk("il_m1_rd",      if_a.m1_rd,          32'hB1B1_B1B1);
        chk("il_m0_rvalid1", 32'(if_a.m0_rvalid), 32'h0);
        chk("il_m0_rd1",     if_a.m0_rd,          32'h0);

        // 6. Reset pulse right after an M1 read grant.
        @(negedge clk);
        if_a.m1_req = 1'b1; if_a.m1_addr = 32'h10;
        #1;
        chk("rr_m1_gnt", 32'(if_a.m1_gnt), 32'h1);
        @(negedge clk);
        if_a.m1_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rr_m1_rvalid_rst", 32'(if_a.m1_rvalid), 32'h0);
        chk("rr_m1_rd_rst",     if_a.m1_rd,          32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        if_a.m0_req = 1'b1; if_a.m0_addr = 32'h40;
        if_a.m1_req = 1'b1; if_a.m1_addr = 32'h44;
        #1;
        chk("rr_tie_m0_gnt",   32'(if_a.m0_gnt),    32'h1);
        chk("rr_tie_m1_gnt",   32'(if_a.m1_gnt),    32'h0);
        chk("rr_m1_rvalid_r0", 32'(if_a.m1_rvalid), 32'h0);
        @(negedge clk);
        #1;
        chk("rr_m1_rvalid_r1", 32'(if_a.m1_rvalid), 32'h0);
        chk("rr_m0_rvalid_r1", 32'(if_a.m0_rvalid), 32'h1);
        chk("rr_m0_gnt_r1",    32'(if_a.m0_gnt),    32'h1);
        if_a.m0_req = 1'b0;
        if_a.m1_req = 1'b0;

        // 3b. BURST_MAX=1: strict alternation M0, M1, M0, M1.
        @(negedge clk);
        if_b.m0_req = 1'b1;
        if_b.m1_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            chk($sformatf("burst1_m0_gnt[%0d]", i), 32'(if_b.m0_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("burst1_m1_gnt[%0d]", i), 32'(if_b.m1_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
        end
        @(negedge clk);
        if_b.m0_req = 1'b0;
        if_b.m1_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
